// File: rtl/bit_packer_pkg.sv
// Shared constants, FSM state type and code-mask helper for the bit_packer entropy-code packer.
package bit_packer_pkg;

  localparam int CODE_W   = 32;
  localparam int OUT_W    = 16;
  localparam int BUF_W    = CODE_W + OUT_W;
  localparam int LEN_W    = $clog2(CODE_W + 1);
  localparam int CNT_W    = $clog2(BUF_W + 1);
  localparam int PAD_HALF = OUT_W / 2;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    PAD   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Mask of the len low-order bits; len >= CODE_W yields all ones.
  function automatic logic [CODE_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [CODE_W:0] m;
    m = ({{CODE_W{1'b0}}, 1'b1} << len) - {{CODE_W{1'b0}}, 1'b1};
    return m[CODE_W-1:0];
  endfunction

endpackage

// File: rtl/bit_packer.sv
// Packs right-aligned variable-length codes MSB-first into 16-bit words, with JPEG 1-fill on flush.
// Optional BIT_PACKER_BYTE_FLUSH_EN: pad boundary of 8 bits and an out_half flag on the final word.
module bit_packer
  import bit_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_in,
  output logic              rdy_out,
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  len,
  output logic              ena_out,
  input  logic              rdy_in,
  output logic [OUT_W-1:0]  out,
  input  logic              flush,
  output logic              done
`ifdef BIT_PACKER_BYTE_FLUSH_EN
  ,
  output logic              out_half
`endif
);

  localparam int SH_W = CNT_W + 1;

  state_t            state, state_next;
  logic [BUF_W-1:0]  buf_q, buf_next, base_buf, ins;
  logic [CNT_W-1:0]  count, count_next, base_cnt;
  logic [SH_W-1:0]   shamt;
  logic [OUT_W-1:0]  pad_word;
  logic              accept, emit;

  assign rdy_out = (state == RUN) & ~flush & (count <= CNT_W'(OUT_W));
  assign out     = buf_q[BUF_W-1 -: OUT_W];

  // Accept and emit only coincide at count == 16, so appending at the
  // post-emit count never lands inside the word currently on out.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    accept     = ena_in & rdy_out;
    emit       = ena_out & rdy_in;
    base_buf   = emit ? (buf_q << OUT_W) : buf_q;
    base_cnt   = emit ? (count - CNT_W'(OUT_W)) : count;
    shamt      = SH_W'(BUF_W) - {1'b0, base_cnt} - {1'b0, len};
    ins        = {{OUT_W{1'b0}}, code & len_mask(len)} << shamt;
    pad_word   = {OUT_W{1'b1}} >> count;
    buf_next   = base_buf;
    count_next = base_cnt;
    state_next = state;

    case (state)
      RUN: begin
        if (accept) begin
          buf_next   = base_buf | ins;
          count_next = base_cnt + CNT_W'(len);
        end else if (flush) begin
          state_next = (base_cnt == '0) ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        if (base_cnt == '0)
          state_next = DONE;
        else if (!ena_out)
          state_next = PAD;
      end
      PAD: begin
        buf_next   = buf_q | {pad_word, {CODE_W{1'b0}}};
        count_next = CNT_W'(OUT_W);
        state_next = DRAIN;
      end
      DONE: begin
        if (!flush) begin
          state_next = RUN;
          buf_next   = '0;
          count_next = '0;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      buf_q   <= '0;
      count   <= '0;
      ena_out <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= state_next;
      buf_q   <= buf_next;
      count   <= count_next;
      ena_out <= (count_next >= CNT_W'(OUT_W));
      done    <= (state_next == DONE);
    end
  end

`ifdef BIT_PACKER_BYTE_FLUSH_EN
  // The pad word carries out_half only when the residual fits in the upper byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_half <= 1'b0;
    else if (state == PAD)
      out_half <= (count <= CNT_W'(PAD_HALF));
    else if (emit)
      out_half <= 1'b0;
  end
`endif

  // Lengths above CODE_W are illegal on an accepted transfer.
  a_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (ena_in && rdy_out) |-> (len <= LEN_W'(CODE_W)));

endmodule
